// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, datapath select codes and RV32I opcodes for the multi-cycle control unit
package ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps opcode/funct3/funct7 to the ALU operation and flags illegal encodings
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_sel,
  output logic       illegal
);
  logic r, i, alt, f7_ok, known;
  always_comb begin
    r     = opcode == OP_R;
    i     = opcode == OP_IMM;
    alt   = funct7 == 7'h20;
    f7_ok = alt || funct7 == 7'h00;
    known = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE};
    alu_sel = ALU_ADD;
    if (r || i)
      case (funct3)
        3'b000:  alu_sel = (r && alt) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_sel = ALU_SLL;
        3'b010:  alu_sel = ALU_SLT;
        3'b011:  alu_sel = ALU_SLTU;
        3'b100:  alu_sel = ALU_XOR;
        3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
        3'b110:  alu_sel = ALU_OR;
        default: alu_sel = ALU_AND;
      endcase
    // SYSTEM covers ECALL/EBREAK; no CSR support, so the whole opcode traps
    illegal = !known || opcode == OP_SYSTEM
            || (r && (!f7_ok || (alt && funct3 != 3'b000 && funct3 != 3'b101)))
            || (i && funct3[1:0] == 2'b01 && (!f7_ok || (alt && !funct3[2])))
            || (opcode == OP_BRANCH && funct3[2:1] == 2'b01);
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle FSM driving datapath selects, ALU op and write enables
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic                 mem_ready,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSel,
  output logic                 ASel,
  output logic                 BSel,
  output logic [2:0]           ImmSel,
  output logic [ALU_SEL_W-1:0] ALUSel,
  output logic                 BrUn,
  output logic                 RegWEn,
  output logic [1:0]           WBSel,
  output logic                 illegal
);
  state_t state, nxt;
  logic [31:0] ir;
  logic [3:0] dec_sel;
  logic dec_ill, r, ld, st, br, jal, jalr, lui, auipc, fence, act, taken;
  logic unused_ir;
  alu_dec u_dec (
    .opcode (ir[6:0]),
    .funct3 (ir[14:12]),
    .funct7 (ir[31:25]),
    .alu_sel(dec_sel),
    .illegal(dec_ill)
  );
  assign unused_ir = ^{ir[24:15], ir[11:7]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= 32'h0000_0013;
    end else begin
      state <= nxt;
      if (state == S_FETCH && mem_ready) ir <= inst;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC:   nxt = br ? S_FETCH : (ld || st) ? S_MEM : S_WB;
      S_MEM:    nxt = !mem_ready ? S_MEM : st ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_TRAP;
    endcase
  end
  always_comb begin
    r     = ir[6:0] == OP_R;
    ld    = ir[6:0] == OP_LOAD;
    st    = ir[6:0] == OP_STORE;
    br    = ir[6:0] == OP_BRANCH;
    jal   = ir[6:0] == OP_JAL;
    jalr  = ir[6:0] == OP_JALR;
    lui   = ir[6:0] == OP_LUI;
    auipc = ir[6:0] == OP_AUIPC;
    fence = ir[6:0] == OP_FENCE;
    // selects stay stable through MEM/WB so the address and jump target hold
    act   = state inside {S_EXEC, S_MEM, S_WB};
    taken = ir[12] ^ (ir[14] ? BrLT : BrEq);
    mem_req = state == S_FETCH || state == S_MEM;
    mem_we  = state == S_MEM && st;
    IRWrite = state == S_FETCH && mem_ready;
    ASel    = act && (auipc || br || jal);
    BSel    = act && !r;
    ImmSel  = !act ? IMM_I : st ? IMM_S : br ? IMM_B : (lui || auipc) ? IMM_U : jal ? IMM_J : IMM_I;
    ALUSel  = act ? dec_sel : ALU_ADD;
    BrUn    = act && br && ir[13];
    RegWEn  = state == S_WB && !fence;
    WBSel   = (state != S_WB || ld) ? WB_MEM : lui ? WB_IMM : (jal || jalr) ? WB_PC4 : WB_ALU;
    PCWrite = state == S_WB || (state == S_EXEC && br) || (state == S_MEM && st && mem_ready);
    PCSel   = (state == S_WB && (jal || jalr)) || (state == S_EXEC && br && taken);
    illegal = state == S_TRAP;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench replaying per-cycle expected control vectors
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, BrEq = 1'b0, BrLT = 1'b0;
  logic [31:0] inst = 32'h0;
  logic mem_req, mem_we, IRWrite, PCWrite, PCSel, ASel, BSel, BrUn, RegWEn, illegal;
  logic [2:0] ImmSel;
  logic [3:0] ALUSel;
  logic [1:0] WBSel;
  logic [18:0] obs;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] inst;
    logic        rdy;
    logic        beq;
    logic        blt;
    logic [18:0] exp;
  } ent_t;
  ent_t sb[$];
  multicycle_ctrl #(.ALU_SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready), .BrEq(BrEq), .BrLT(BrLT),
    .mem_req(mem_req), .mem_we(mem_we), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
    .ASel(ASel), .BSel(BSel), .ImmSel(ImmSel), .ALUSel(ALUSel), .BrUn(BrUn), .RegWEn(RegWEn),
    .WBSel(WBSel), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs = {mem_req, mem_we, IRWrite, PCWrite, PCSel, ASel, BSel, ImmSel, ALUSel, BrUn, RegWEn, WBSel, illegal};
  function automatic logic [18:0] ev(input int mr, mw, irw, pcw, pcs, as, bs, imm, alu, bu, rw, wb, ill);
    return {mr[0], mw[0], irw[0], pcw[0], pcs[0], as[0], bs[0], imm[2:0], alu[3:0], bu[0], rw[0], wb[1:0], ill[0]};
  endfunction
  task automatic push(input logic [31:0] i, input logic r, b, l, input logic [18:0] e);
    ent_t x;
    x.inst = i; x.rdy = r; x.beq = b; x.blt = l; x.exp = e;
    sb.push_back(x);
  endtask
  task automatic push_fd(input logic [31:0] i, input int fwait);
    for (int k = 0; k < fwait; k++) push(i, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
    push(i, 1'b1, 1'b0, 1'b0, ev(1,0,1,0,0,0,0,0,0,0,0,0,0));
    push(i, 1'b1, 1'b0, 1'b0, '0);
  endtask
  task automatic push_std(input logic [31:0] i, input int fwait, input logic [18:0] ex, wb);
    push_fd(i, fwait);
    push(i, 1'b1, 1'b0, 1'b0, ex);
    push(i, 1'b1, 1'b0, 1'b0, wb);
  endtask
  task automatic tick(input ent_t e);
    @(posedge clk);
    #1;
    inst = e.inst; mem_ready = e.rdy; BrEq = e.beq; BrLT = e.blt;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; inst = 32'h0; BrEq = 1'b0; BrLT = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_idle: got %h want 0", obs); end
  endtask
  task automatic test_add();
    ent_t e;
    int n = 0;
    test_reset();
    push_std(32'h002081B3, 0, '0, ev(0,0,0,1,0,0,0,0,0,0,1,1,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); tick(e); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL add step %0d: got %h want %h", n, obs, e.exp); end
      n++;
    end
  endtask
  task automatic test_back_to_back();
    ent_t e;
    int n = 0;
    test_reset();
    push_std(32'h40208233, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0), ev(0,0,0,1,0,0,0,0,1,0,1,1,0));
    push_std(32'h4030D093, 0, ev(0,0,0,0,0,0,1,0,7,0,0,0,0), ev(0,0,0,1,0,0,1,0,7,0,1,1,0));
    push_std(32'h0000000F, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0), ev(0,0,0,1,0,0,1,0,0,0,0,1,0));
    push_std(32'h123450B7, 2, ev(0,0,0,0,0,0,1,3,0,0,0,0,0), ev(0,0,0,1,0,0,1,3,0,0,1,3,0));
    push_std(32'h00001097, 0, ev(0,0,0,0,0,1,1,3,0,0,0,0,0), ev(0,0,0,1,0,1,1,3,0,0,1,1,0));
    push_std(32'h010000EF, 0, ev(0,0,0,0,0,1,1,4,0,0,0,0,0), ev(0,0,0,1,1,1,1,4,0,0,1,2,0));
    push_std(32'h000100E7, 0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0), ev(0,0,0,1,1,0,1,0,0,0,1,2,0));
    push_fd(32'h0020A423, 0);
    push(32'h0020A423, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,1,0,0,0,0,0));
    push(32'h0020A423, 1'b1, 1'b0, 1'b0, ev(1,1,0,1,0,0,1,1,0,0,0,0,0));
    push_fd(32'h002081B3, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); tick(e); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL b2b step %0d: got %h want %h", n, obs, e.exp); end
      n++;
    end
  endtask
  task automatic test_branch();
    ent_t e;
    int n = 0;
    test_reset();
    push_fd(32'h00208463, 0);
    push(32'h00208463, 1'b1, 1'b1, 1'b0, ev(0,0,0,1,1,1,1,2,0,0,0,0,0));
    push_fd(32'h00209463, 0);
    push(32'h00209463, 1'b1, 1'b1, 1'b0, ev(0,0,0,1,0,1,1,2,0,0,0,0,0));
    push_fd(32'h0020E463, 0);
    push(32'h0020E463, 1'b1, 1'b0, 1'b1, ev(0,0,0,1,1,1,1,2,0,1,0,0,0));
    push_fd(32'h0020F463, 0);
    push(32'h0020F463, 1'b1, 1'b0, 1'b1, ev(0,0,0,1,0,1,1,2,0,1,0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); tick(e); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL branch step %0d: got %h want %h", n, obs, e.exp); end
      n++;
    end
  endtask
  task automatic test_load_wait();
    ent_t e;
    int n = 0;
    test_reset();
    push_fd(32'h0040A283, 0);
    push(32'h0040A283, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++) push(32'h0040A283, k == 3, 1'b0, 1'b0, ev(1,0,0,0,0,0,1,0,0,0,0,0,0));
    push(32'h0040A283, 1'b1, 1'b0, 1'b0, ev(0,0,0,1,0,0,1,0,0,0,1,0,0));
    push(32'h0040A283, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); tick(e); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL load step %0d: got %h want %h", n, obs, e.exp); end
      n++;
    end
  endtask
  task automatic test_reset_mid_store();
    ent_t e;
    int n = 0;
    test_reset();
    push_fd(32'h0020A423, 0);
    push(32'h0020A423, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,1,0,0,0,0,0));
    push(32'h0020A423, 1'b0, 1'b0, 1'b0, ev(1,1,0,0,0,0,1,1,0,0,0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); tick(e); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL store step %0d: got %h want %h", n, obs, e.exp); end
      n++;
    end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
    @(posedge clk);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL post_reset_idle: got %h want 0", obs); end
    @(negedge clk);
    checks++;
    if (obs !== ev(1,0,1,0,0,0,0,0,0,0,0,0,0)) begin
      errors++; $display("FAIL post_reset_fetch: got %h want %h", obs, ev(1,0,1,0,0,0,0,0,0,0,0,0,0));
    end
  endtask
  task automatic test_illegal();
    logic [31:0] bad [4];
    ent_t e;
    int n;
    bad[0] = 32'h40309093; bad[1] = 32'h0020A463; bad[2] = 32'h00000073; bad[3] = 32'h0000007F;
    for (int k = 0; k < 4; k++) begin
      test_reset();
      n = 0;
      push_fd(bad[k], 0);
      for (int c = 0; c < (k == 3 ? 20 : 2); c++) push(bad[k], 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0,0,1));
      while (sb.size() > 0) begin
        e = sb.pop_front(); tick(e); checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL illegal %h step %0d: got %h want %h", bad[k], n, obs, e.exp); end
        n++;
      end
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_load_wait();
    test_reset_mid_store();
    test_illegal();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the ALU's 4-bit `ALUSel` operation code, the datapath multiplexer selects and the register/memory/PC write enables. It sits between the unified instruction/data memory port and the existing datapath (ALU, register file, immediate generator, branch comparator). It latches its own copy of the instruction word.

## Interface
- `ALU_SEL_W`, 4: width of `ALUSel`; fixed by the ALU, do not override.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `inst`  in  32: memory read data; captured into the internal IR on fetch completion.
- `mem_ready`  in  1: memory access complete; sampled only while `mem_req`=1.
- `BrEq`, `BrLT`  in  1 each: branch comparator results.
- `mem_req`  out  1: memory access request; held until `mem_ready`.
- `mem_we`  out  1: store access when 1.
- `IRWrite`  out  1: IR load strobe (informational copy for the datapath).
- `PCWrite`  out  1: PC update enable.
- `PCSel`  out  1: 0 = PC+4, 1 = ALU result.
- `ASel`  out  1: 0 = rs1, 1 = PC.
- `BSel`  out  1: 0 = rs2, 1 = immediate.
- `ImmSel`  out  3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `ALUSel`  out  4: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
- `BrUn`  out  1: unsigned compare; equals funct3[1].
- `RegWEn`  out  1: register file write enable.
- `WBSel`  out  2: 0 = memory, 1 = ALU, 2 = PC+4, 3 = immediate.
- `illegal`  out  1: sticky trap flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- All outputs are decoded from the state and the internal IR. Every output is 0 in IDLE and TRAP, except `illegal`, which is 1 in TRAP.
- IDLE → FETCH on the first clock after `rst_n` rises.
- FETCH: `mem_req`=1 and `mem_we`=0. When `mem_ready`=1, assert `IRWrite`, load the IR and go to DECODE.
- DECODE: one cycle. Go to TRAP if the instruction is illegal, otherwise go to EXEC.
- ALU decode:
  - funct3 000 selects add, or sub when the op is R-type and funct7[5]=1.
  - funct3 001 selects sll, 010 slt, 011 sltu, 100 xor.
  - funct3 101 selects srl, or sra when funct7[5]=1.
  - funct3 110 selects or, 111 and.
  - funct7[5] is ignored for addi.
- Illegal conditions:
  - Unknown opcode.
  - R-type funct7 other than 0x00 or 0x20, or 0x20 with funct3 other than 000 or 101.
  - Shift-immediate funct7 other than 0x00 or 0x20, or 0x20 on slli.
  - Branch funct3 010 or 011.
  - ECALL and EBREAK.
- FENCE is a no-op. It follows the ALU-op path with `RegWEn`=0.
- Paths by instruction class:
  - R/I-ALU: EXEC (ASel=0, BSel=R?0:1, ImmSel=I), then WB (RegWEn=1, WBSel=1, PCWrite=1, PCSel=0), then FETCH.
  - LUI: EXEC, then WB with WBSel=3 (ImmSel=U).
  - AUIPC: EXEC with ASel=1, BSel=1 and add, then WB with WBSel=1.
  - LOAD: EXEC (add rs1+I-imm), then MEM (mem_req=1, mem_we=0, held until mem_ready), then WB (WBSel=0), then FETCH.
  - STORE: EXEC (ImmSel=S), then MEM with mem_we=1. On `mem_ready`, PCWrite=1 and PCSel=0, then FETCH.
  - BRANCH: EXEC (ASel=1, BSel=1, ImmSel=B, add) with PCWrite=1, then FETCH.
    - PCSel=1 when taken: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT.
  - JAL: EXEC (ASel=1, ImmSel=J, add), then WB (RegWEn=1, WBSel=2, PCWrite=1, PCSel=1).
  - JALR: same as JAL, but ASel=0 and ImmSel=I.
- TRAP is absorbing; only `rst_n` leaves it.

## Timing
- Cycles with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3. Each wait cycle on `mem_ready` adds one.
- `mem_req` rises in the cycle the state enters FETCH or MEM. It falls the cycle after `mem_ready` is sampled high.
- `mem_ready` asserted while `mem_req`=0 is ignored.
- Reset asserted mid-access: state goes to IDLE immediately and all outputs go to 0. The access is abandoned with no PC or register writes. The IR resets to 0x00000013 (nop).
- Exactly one `PCWrite` pulse per retired instruction, in its last cycle.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - the ALUSel, ImmSel and WBSel constants;
  - the RV32I opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17, 0x0F, 0x73).
- Sub-module `alu_dec` is combinational. It maps opcode, funct3 and funct7 to `ALUSel` plus an illegal flag.

## Test plan
- `add x3,x1,x2` (0x002081B3), mem_ready always 1 → states FETCH, DECODE, EXEC, WB. In EXEC, ALUSel=0. In WB, RegWEn=1, WBSel=1, PCWrite=1.
- `srai` with funct7=0x20 and funct3=101 → ALUSel=7 with BSel=1. Same funct7 on `slli` → TRAP, illegal=1.
- `beq` with BrEq=1 → PCWrite=1 and PCSel=1 in cycle 3. `bne` with BrEq=1 → PCSel=0. `bltu` → BrUn=1.
- `lw` with mem_ready delayed 3 cycles in MEM → mem_req held for 4 cycles, WBSel=0 in WB, 8 cycles total.
- `sw` with `rst_n` pulled low during MEM → all outputs 0 asynchronously. After release: IDLE, then FETCH with mem_req=1 and no PCWrite pulse.
- Opcode 0x7F → TRAP. `illegal` stays 1 and no further mem_req for 20 cycles.
